pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Controls the 16-bit program counter: drives its load, count-enable, output-enable and reset strobes.
- Runs instruction fetch against instruction memory over a req/ack handshake, with an optional second fetch for an immediate word.
- Presents the fetched instruction to the execute stage over a valid/ready handshake.
- Executes jumps by strobing a counter load from the shared bus.

Parameters:
- IMM_BIT, 15: instruction bit that, when set, makes the next word an immediate to be fetched.
- TIMEOUT_CYCLES, 15: maximum FETCH/IMM dwell without mem_ack before bus error; legal range 1..255.

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- run  input  1  level; enables fetching
- pc_notReset  output  1  to counter notReset; equals ~reset (combinational)
- pc_notLoad  output  1  to counter notLoad; active low
- pc_notOE  output  1  to counter notOE; active low; drives PC onto address bus
- pc_inc  output  1  to counter inc; count enable
- mem_req  output  1  instruction-memory request
- mem_ack  input  1  memory has valid mem_data this cycle
- mem_data  input  16  instruction-memory read data
- ir  output  16  fetched instruction
- imm  output  16  fetched immediate; 0 if none
- ir_valid  output  1  ir/imm valid for execute stage
- ir_ready  input  1  execute stage accepts ir/imm
- jump_req  input  1  execute stage requests PC load; target is already on the counter input bus
- jump_ack  output  1  one-cycle pulse; load performed this cycle
- bus_err  output  1  sticky memory-timeout flag

Behaviour:
- States: IDLE, FETCH, IMM, ISSUE, JUMP, HALT. Registered state and wait counter (8 bits).
- Reset (sync, any state, mid-handshake included):
  - state=IDLE; ir=0, imm=0, ir_valid=0, jump_ack=0, bus_err=0, wait counter=0.
  - pc_notLoad=1, pc_notOE=1, pc_inc=0, mem_req=0.
  - pc_notReset=0 while reset is high, so the counter clears to 0 on the same edge.
- IDLE:
  - jump_req=1 -> JUMP (priority over run).
  - else run=1 -> FETCH.
  - else stay.
- FETCH:
  - mem_req=1 and pc_notOE=0.
  - On mem_ack=1: ir<=mem_data, imm<=0, pc_inc=1 in that same cycle (Mealy; counter advances on the capture edge), wait counter cleared.
  - Then -> IMM if mem_data[IMM_BIT]=1, else -> ISSUE.
  - Single-cycle fetch possible: ack in first FETCH cycle.
- IMM:
  - Same as FETCH, except capture goes to imm<=mem_data, then -> ISSUE.
- Timeout (FETCH/IMM):
  - Wait counter increments each cycle without ack.
  - If the counter reaches TIMEOUT_CYCLES-1 and ack is still absent: -> HALT, bus_err<=1, no capture, no pc_inc.
  - Ack on the final allowed cycle is accepted normally.
- ISSUE:
  - ir_valid=1; ir/imm held stable until the handshake.
  - Handshake = ir_valid & ir_ready. On the handshake edge, ir_valid drops next cycle unless re-issued. Next state:
    - jump_req=1 -> JUMP (jump wins over run);
    - else run=1 -> FETCH;
    - else -> IDLE.
  - jump_req without ir_ready is ignored; stay in ISSUE.
  - Dropping run during FETCH/IMM does not abort; the word completes and is issued.
- JUMP:
  - Exactly one cycle: pc_notLoad=0, jump_ack=1, pc_inc=0, pc_notOE=1, mem_req=0.
  - Next: -> FETCH if run, else IDLE.
- HALT:
  - All strobes inactive, bus_err=1, ir_valid=0. Left only by reset.
- Invariants:
  - pc_inc and ~pc_notLoad never both asserted.
  - pc_notOE=0 only in FETCH/IMM.
  - mem_req=1 exactly in FETCH/IMM.
  - pc_inc only when mem_ack is accepted.
- PC advance per instruction: +1 word (+2 bytes at the counter output) for a plain instruction; +2 words with an immediate.

Test Plan:
- Reset mid-IMM with mem_ack pending -> next cycle state IDLE, mem_req=0, ir_valid=0, ir=0, imm=0, pc_notReset=0 during reset; counter output then reads 0x0000.
- run=1, memory acks in 1 cycle with 0x1234 -> ir=0x1234, imm=0, ir_valid in the 2nd cycle after FETCH entry; pc_inc asserted exactly once; counter output 0x0002.
- Fetch 0x8001 (bit15 set), ack after 3 waits, then 0xBEEF -> ir=0x8001, imm=0xBEEF; pc_inc pulses twice; counter output +4 bytes.
- In ISSUE, ir_ready=1 with jump_req=1, bus target 0x0040 -> one JUMP cycle: pc_notLoad=0, jump_ack=1, pc_inc=0; next FETCH presents 0x0040 with pc_notOE=0.
- ir_ready held low for 10 cycles -> ir_valid stays 1, ir unchanged, no mem_req, pc_inc=0 throughout.
- mem_ack never arrives, TIMEOUT_CYCLES=15 -> after 15 FETCH cycles: HALT, bus_err=1, mem_req=0; later run/jump_req/mem_ack ignored until reset clears bus_err.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer: fetches instruction (and optional immediate)
// words over req/ack, issues them over valid/ready, and performs PC jumps.
module pc_fetch_sequencer #(
    parameter int unsigned IMM_BIT        = 15,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic        pc_notReset,
    output logic        pc_notLoad,
    output logic        pc_notOE,
    output logic        pc_inc,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] ir,
    output logic [15:0] imm,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        jump_req,
    output logic        jump_ack,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        IMM   = 3'd2,
        ISSUE = 3'd3,
        JUMP  = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] imm_q, imm_d;
    logic        ir_valid_q, ir_valid_d;
    logic        jump_ack_q, jump_ack_d;
    logic        bus_err_q, bus_err_d;
    logic        mem_req_q, mem_req_d;
    logic        not_oe_q, not_oe_d;
    logic        not_load_q, not_load_d;

    logic        fetching;
    logic        expired;

    assign fetching = (state_q == FETCH) || (state_q == IMM);
    assign expired  = fetching && !mem_ack && (wait_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        ir_d      = ir_q;
        imm_d     = imm_q;
        bus_err_d = bus_err_q;

        case (state_q)
            IDLE: begin
                if (jump_req)  state_d = JUMP;
                else if (run)  state_d = FETCH;
            end
            FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_data;
                    imm_d   = '0;
                    state_d = mem_data[IMM_BIT] ? IMM : ISSUE;
                end else if (expired) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            IMM: begin
                if (mem_ack) begin
                    imm_d   = mem_data;
                    state_d = ISSUE;
                end else if (expired) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ISSUE: begin
                // jump_req is only honoured together with the issue handshake
                if (ir_ready) begin
                    if (jump_req)  state_d = JUMP;
                    else if (run)  state_d = FETCH;
                    else           state_d = IDLE;
                end
            end
            JUMP: begin
                state_d = run ? FETCH : IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they are registered outputs
        ir_valid_d = (state_d == ISSUE);
        mem_req_d  = (state_d == FETCH) || (state_d == IMM);
        not_oe_d   = !mem_req_d;
        not_load_d = (state_d != JUMP);
        jump_ack_d = (state_d == JUMP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            ir_q       <= '0;
            imm_q      <= '0;
            ir_valid_q <= 1'b0;
            jump_ack_q <= 1'b0;
            bus_err_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            not_oe_q   <= 1'b1;
            not_load_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ir_q       <= ir_d;
            imm_q      <= imm_d;
            ir_valid_q <= ir_valid_d;
            jump_ack_q <= jump_ack_d;
            bus_err_q  <= bus_err_d;
            mem_req_q  <= mem_req_d;
            not_oe_q   <= not_oe_d;
            not_load_q <= not_load_d;
        end
    end

    // Counter advances on the same edge that captures the acknowledged word
    assign pc_inc      = fetching && mem_ack && !reset;
    assign pc_notReset = ~reset;
    assign pc_notLoad  = not_load_q;
    assign pc_notOE    = not_oe_q;
    assign mem_req     = mem_req_q;
    assign ir          = ir_q;
    assign imm         = imm_q;
    assign ir_valid    = ir_valid_q;
    assign jump_ack    = jump_ack_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed stimulus, scoreboard of issued words,
// and a behavioural 16-bit byte-address program counter driven by the strobes.
module tb_pc_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic        run;
    logic        pc_notReset;
    logic        pc_notLoad;
    logic        pc_notOE;
    logic        pc_inc;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic [15:0] imm;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump_req;
    logic        jump_ack;
    logic        bus_err;

    logic [15:0] pc_bus;
    logic [15:0] pc_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    pc_fetch_sequencer #(
        .IMM_BIT       (15),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .pc_notReset(pc_notReset),
        .pc_notLoad (pc_notLoad),
        .pc_notOE   (pc_notOE),
        .pc_inc     (pc_inc),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .ir         (ir),
        .imm        (imm),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .jump_req   (jump_req),
        .jump_ack   (jump_ack),
        .bus_err    (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External counter: byte address, +2 per word
    always @(posedge clock) begin
        if (!pc_notReset)     pc_cnt <= 16'h0000;
        else if (!pc_notLoad) pc_cnt <= pc_bus;
        else if (pc_inc)      pc_cnt <= pc_cnt + 16'd2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor plus per-cycle strobe invariants
    always @(negedge clock) begin
        if (!reset) begin
            chk("inv_inc_and_load", {31'd0, pc_inc & ~pc_notLoad}, 32'd0);
            chk("inv_req_vs_oe", {31'd0, mem_req}, {31'd0, ~pc_notOE});
        end
        if (ir_valid && ir_ready) begin
            if (exp_q.size() == 0) begin
                chk("issue_unexpected", {ir, imm}, 32'hDEAD_DEAD);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("issue_ir", {16'd0, ir}, {16'd0, e[31:16]});
                chk("issue_imm", {16'd0, imm}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    initial begin
        reset    = 1'b1;
        run      = 1'b0;
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
        ir_ready = 1'b0;
        jump_req = 1'b0;
        pc_bus   = 16'h0000;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        at_neg();
        chk("rst_notReset", {31'd0, pc_notReset}, 32'd0);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_notOE", {31'd0, pc_notOE}, 32'd1);
        chk("rst_notLoad", {31'd0, pc_notLoad}, 32'd1);
        chk("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
        chk("rst_jump_ack", {31'd0, jump_ack}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_ir", {16'd0, ir}, 32'd0);
        chk("rst_imm", {16'd0, imm}, 32'd0);
        chk("rst_pc", {16'd0, pc_cnt}, 32'd0);

        // Plain instruction, single-cycle ack
        tick(); reset = 1'b0; run = 1'b1;
        at_neg();
        chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
        chk("idle_notReset", {31'd0, pc_notReset}, 32'd1);
        tick(); mem_ack = 1'b1; mem_data = 16'h1234; exp_q.push_back(32'h1234_0000);
        at_neg();
        chk("f1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f1_notOE", {31'd0, pc_notOE}, 32'd0);
        chk("f1_pc_inc", {31'd0, pc_inc}, 32'd1);
        chk("f1_ir_valid", {31'd0, ir_valid}, 32'd0);
        tick(); mem_ack = 1'b0; run = 1'b0; ir_ready = 1'b1;
        at_neg();
        chk("i1_ir_valid", {31'd0, ir_valid}, 32'd1);
        chk("i1_pc_inc", {31'd0, pc_inc}, 32'd0);
        chk("i1_mem_req", {31'd0, mem_req}, 32'd0);
        chk("i1_pc", {16'd0, pc_cnt}, 32'h0002);
        tick(); ir_ready = 1'b0; run = 1'b1;
        at_neg();
        chk("i1_drop_valid", {31'd0, ir_valid}, 32'd0);
        chk("i1_pc_hold", {16'd0, pc_cnt}, 32'h0002);

        // Instruction with immediate, three wait cycles before the first ack
        tick(); mem_data = 16'h8001; mem_ack = 1'b0; exp_q.push_back(32'h8001_BEEF);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("f2_wait_req", {31'd0, mem_req}, 32'd1);
            chk("f2_wait_inc", {31'd0, pc_inc}, 32'd0);
            tick();
        end
        mem_ack = 1'b1;
        at_neg();
        chk("f2_ack_inc", {31'd0, pc_inc}, 32'd1);
        chk("f2_ack_pc", {16'd0, pc_cnt}, 32'h0002);
        tick(); mem_data = 16'hBEEF; mem_ack = 1'b1;
        at_neg();
        chk("imm_mem_req", {31'd0, mem_req}, 32'd1);
        chk("imm_notOE", {31'd0, pc_notOE}, 32'd0);
        chk("imm_pc_inc", {31'd0, pc_inc}, 32'd1);
        chk("imm_pc", {16'd0, pc_cnt}, 32'h0004);
        chk("imm_ir", {16'd0, ir}, 32'h8001);

        // Back-pressure: ir_ready low for 10 cycles
        tick(); mem_ack = 1'b0; run = 1'b0; ir_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            chk("bp_valid", {31'd0, ir_valid}, 32'd1);
            chk("bp_ir", {16'd0, ir}, 32'h8001);
            chk("bp_imm", {16'd0, imm}, 32'hBEEF);
            chk("bp_mem_req", {31'd0, mem_req}, 32'd0);
            chk("bp_pc_inc", {31'd0, pc_inc}, 32'd0);
            chk("bp_pc", {16'd0, pc_cnt}, 32'h0006);
            tick();
        end

        // Handshake together with a jump to 0x0040
        ir_ready = 1'b1; jump_req = 1'b1; run = 1'b1; pc_bus = 16'h0040;
        at_neg();
        tick(); ir_ready = 1'b0; jump_req = 1'b0;
        at_neg();
        chk("j_notLoad", {31'd0, pc_notLoad}, 32'd0);
        chk("j_jump_ack", {31'd0, jump_ack}, 32'd1);
        chk("j_pc_inc", {31'd0, pc_inc}, 32'd0);
        chk("j_notOE", {31'd0, pc_notOE}, 32'd1);
        chk("j_mem_req", {31'd0, mem_req}, 32'd0);
        chk("j_ir_valid", {31'd0, ir_valid}, 32'd0);
        tick();
        at_neg();
        chk("jf_pc", {16'd0, pc_cnt}, 32'h0040);
        chk("jf_notOE", {31'd0, pc_notOE}, 32'd0);
        chk("jf_mem_req", {31'd0, mem_req}, 32'd1);
        chk("jf_jump_ack", {31'd0, jump_ack}, 32'd0);
        chk("jf_notLoad", {31'd0, pc_notLoad}, 32'd1);

        // No ack ever: 15 FETCH cycles then HALT
        for (int i = 2; i <= 15; i++) begin
            tick();
            at_neg();
            chk("to_mem_req", {31'd0, mem_req}, 32'd1);
            chk("to_bus_err", {31'd0, bus_err}, 32'd0);
        end
        tick();
        at_neg();
        chk("halt_bus_err", {31'd0, bus_err}, 32'd1);
        chk("halt_mem_req", {31'd0, mem_req}, 32'd0);
        chk("halt_notOE", {31'd0, pc_notOE}, 32'd1);
        chk("halt_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("halt_pc", {16'd0, pc_cnt}, 32'h0040);
        run = 1'b1; jump_req = 1'b1; mem_ack = 1'b1; mem_data = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            at_neg();
            chk("halt_hold_err", {31'd0, bus_err}, 32'd1);
            chk("halt_hold_req", {31'd0, mem_req}, 32'd0);
            chk("halt_hold_jack", {31'd0, jump_ack}, 32'd0);
            chk("halt_hold_load", {31'd0, pc_notLoad}, 32'd1);
            chk("halt_hold_inc", {31'd0, pc_inc}, 32'd0);
            chk("halt_hold_pc", {16'd0, pc_cnt}, 32'h0040);
        end

        // Reset clears HALT
        tick(); reset = 1'b1; jump_req = 1'b0; mem_ack = 1'b0; run = 1'b0;
        at_neg();
        chk("hr_notReset", {31'd0, pc_notReset}, 32'd0);
        tick(); reset = 1'b0; run = 1'b1;
        at_neg();
        chk("hr_bus_err", {31'd0, bus_err}, 32'd0);
        chk("hr_pc", {16'd0, pc_cnt}, 32'h0000);
        chk("hr_mem_req", {31'd0, mem_req}, 32'd0);

        // Reset mid-IMM with ack pending
        tick(); mem_ack = 1'b1; mem_data = 16'h8002;
        at_neg();
        chk("rm_f_inc", {31'd0, pc_inc}, 32'd1);
        tick(); mem_ack = 1'b1; mem_data = 16'h5555; reset = 1'b1;
        at_neg();
        chk("rm_inc_gated", {31'd0, pc_inc}, 32'd0);
        chk("rm_notReset", {31'd0, pc_notReset}, 32'd0);
        tick(); reset = 1'b0; run = 1'b0; mem_ack = 1'b0;
        at_neg();
        chk("rm_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rm_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rm_ir", {16'd0, ir}, 32'd0);
        chk("rm_imm", {16'd0, imm}, 32'd0);
        chk("rm_pc", {16'd0, pc_cnt}, 32'h0000);
        chk("rm_notOE", {31'd0, pc_notOE}, 32'd1);
        tick();
        at_neg();
        chk("rm_idle_req", {31'd0, mem_req}, 32'd0);
        chk("rm_idle_valid", {31'd0, ir_valid}, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
